// File: rtl/quad_encoder_emulator_pkg.sv
// Shared quadrature definitions: the {a,b} position encoding and one-step moves
// along the forward (Q00->Q10->Q11->Q01) and backward sequences.
package quad_encoder_emulator_pkg;

    typedef enum logic [1:0] {
        Q00 = 2'b00,
        Q10 = 2'b10,
        Q11 = 2'b11,
        Q01 = 2'b01
    } quad_state_t;

    function automatic quad_state_t quad_next(input quad_state_t q);
        quad_state_t r;
        unique case (q)
            Q00:     r = Q10;
            Q10:     r = Q11;
            Q11:     r = Q01;
            Q01:     r = Q00;
            default: r = Q00;
        endcase
        return r;
    endfunction

    function automatic quad_state_t quad_prev(input quad_state_t q);
        quad_state_t r;
        unique case (q)
            Q00:     r = Q01;
            Q01:     r = Q11;
            Q11:     r = Q10;
            Q10:     r = Q00;
            default: r = Q00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/quad_encoder_emulator_edge_timer.sv
// Saturating cycles-since-last-edge counter; o_expired means another edge may be emitted.
module quad_encoder_emulator_edge_timer #(
    parameter int PERIOD_WIDTH = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_clear,
    input  logic [PERIOD_WIDTH-1:0] i_period,
    output logic                    o_expired
);

    localparam logic [PERIOD_WIDTH-1:0] P_ONE = {{(PERIOD_WIDTH-1){1'b0}}, 1'b1};

    logic [PERIOD_WIDTH-1:0] timer_q, timer_d;
    logic [PERIOD_WIDTH-1:0] period_eff;

    always_comb begin
        timer_d = timer_q;
        if (i_clear) begin
            timer_d = '0;
        end else if (timer_q != '1) begin
            timer_d = timer_q + P_ONE;
        end
    end

    // Starting saturated lets the first edge after reset go out without delay.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            timer_q <= '1;
        end else begin
            timer_q <= timer_d;
        end
    end

    assign period_eff = (i_period == '0) ? P_ONE : i_period;
    assign o_expired  = (timer_q >= (period_eff - P_ONE));

endmodule

// File: rtl/quad_encoder_emulator.sv
// Quadrature A/B generator: step requests accumulate in a signed pending counter
// which is drained one A/B edge at a time, no faster than the programmed spacing.
module quad_encoder_emulator
    import quad_encoder_emulator_pkg::*;
#(
    parameter int CNT_WIDTH    = 16,
    parameter int PERIOD_WIDTH = 16
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_step,
    input  logic                        i_dir,
    input  logic                        i_polarity,
    input  logic [PERIOD_WIDTH-1:0]     i_period,
    input  logic                        i_enable,
    input  logic                        i_clear,
    output logic                        o_a,
    output logic                        o_b,
    output logic signed [CNT_WIDTH-1:0] o_pending,
    output logic                        o_busy,
    output logic                        o_overflow
);

    localparam logic signed [CNT_WIDTH:0] LIMIT     = {2'b00, {(CNT_WIDTH-1){1'b1}}};
    localparam logic signed [CNT_WIDTH:0] NEG_LIMIT = -LIMIT;
    localparam logic signed [CNT_WIDTH:0] ONE       = {{CNT_WIDTH{1'b0}}, 1'b1};
    localparam logic signed [CNT_WIDTH:0] MINUS_ONE = '1;

    quad_state_t                 state_q, state_d;
    logic signed [CNT_WIDTH-1:0] pending_q, pending_d;
    logic                        overflow_q, overflow_d;

    logic                        expired;
    logic                        emit;
    logic                        pending_nz;
    logic                        pending_pos;
    logic                        step_fwd;
    logic signed [CNT_WIDTH:0]   pend_ext;
    logic signed [CNT_WIDTH:0]   req_delta;
    logic signed [CNT_WIDTH:0]   emit_delta;
    logic signed [CNT_WIDTH:0]   after_emit;
    logic signed [CNT_WIDTH:0]   net;
    logic                        saturate;

    quad_encoder_emulator_edge_timer #(
        .PERIOD_WIDTH(PERIOD_WIDTH)
    ) u_timer (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_clear   (emit),
        .i_period  (i_period),
        .o_expired (expired)
    );

    assign pending_nz  = |pending_q;
    assign pending_pos = pending_nz & ~pending_q[CNT_WIDTH-1];
    assign emit        = i_enable & ~i_clear & pending_nz & expired;

    // Positive steps run forward when polarity is 1, so a reader with the same
    // polarity reports the requested direction.
    assign step_fwd = (pending_pos == i_polarity);

    // One extra bit of headroom so the saturation test sees the true net value.
    always_comb begin
        pend_ext   = {pending_q[CNT_WIDTH-1], pending_q};
        req_delta  = i_step ? (i_dir ? ONE : MINUS_ONE) : '0;
        emit_delta = emit ? (pending_pos ? ONE : MINUS_ONE) : '0;
        after_emit = pend_ext - emit_delta;
        net        = after_emit + req_delta;
        saturate   = (net > LIMIT) || (net < NEG_LIMIT);
    end

    always_comb begin
        pending_d  = net[CNT_WIDTH-1:0];
        overflow_d = 1'b0;
        if (i_clear) begin
            pending_d = '0;
        end else if (i_step && saturate) begin
            pending_d  = after_emit[CNT_WIDTH-1:0];
            overflow_d = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        if (emit) begin
            state_d = step_fwd ? quad_next(state_q) : quad_prev(state_q);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= Q00;
            pending_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
        end
    end

    assign o_a        = state_q[1];
    assign o_b        = state_q[0];
    assign o_pending  = pending_q;
    assign o_busy     = pending_nz;
    assign o_overflow = overflow_q;

endmodule

// File: tb/tb_quad_encoder_emulator.sv
// Bench for quad_encoder_emulator: a wide (16-bit) and a narrow (4-bit) instance share
// one stimulus stream and are checked every cycle against a position/count model.
module tb_quad_encoder_emulator;

    localparam int CW0 = 16;
    localparam int CW1 = 4;
    localparam int PW  = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          step = 1'b0;
    logic          dir = 1'b0;
    logic          pol = 1'b1;
    logic          en = 1'b0;
    logic          clr = 1'b0;
    logic [PW-1:0] period = '0;

    logic                  a0, b0, busy0, ovf0;
    logic                  a1, b1, busy1, ovf1;
    logic signed [CW0-1:0] pend0;
    logic signed [CW1-1:0] pend1;

    always #5 clk = ~clk;

    quad_encoder_emulator #(.CNT_WIDTH(CW0), .PERIOD_WIDTH(PW)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_step(step), .i_dir(dir), .i_polarity(pol),
        .i_period(period), .i_enable(en), .i_clear(clr),
        .o_a(a0), .o_b(b0), .o_pending(pend0), .o_busy(busy0), .o_overflow(ovf0)
    );

    quad_encoder_emulator #(.CNT_WIDTH(CW1), .PERIOD_WIDTH(PW)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_step(step), .i_dir(dir), .i_polarity(pol),
        .i_period(period), .i_enable(en), .i_clear(clr),
        .o_a(a1), .o_b(b1), .o_pending(pend1), .o_busy(busy1), .o_overflow(ovf1)
    );

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Position is an unbounded integer walk; A/B is its Gray code mod 4.
    int  lim[2] = '{32767, 7};
    int  m_pend[2];
    int  m_pos[2];
    int  m_tmr[2];
    bit  m_ovf[2];
    bit  rst_at_edge = 1'b1;
    int  cyc = 0;
    int  np, nq, nt;
    bit  no;

    function automatic logic [1:0] pos_to_ab(input int pos);
        case (pos & 3)
            0: return 2'b00;
            1: return 2'b10;
            2: return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    function automatic int ab_to_idx(input logic [1:0] ab);
        case (ab)
            2'b00: return 0;
            2'b10: return 1;
            2'b11: return 2;
            default: return 3;
        endcase
    endfunction

    function automatic void model_next(input int k, input int pend, input int pos, input int tmr,
                                       output int npend, output int npos, output int ntmr,
                                       output bit novf);
        int per, req, sgn;
        per   = (period == '0) ? 1 : int'(period);
        npend = pend;
        npos  = pos;
        novf  = 1'b0;
        ntmr  = (tmr >= 65535) ? 65535 : tmr + 1;
        if (clr) begin
            npend = 0;
        end else begin
            if (en && pend != 0 && tmr >= per - 1) begin
                sgn   = (pend > 0) ? 1 : -1;
                npos  = pos + ((((sgn > 0) ? 1'b1 : 1'b0) == pol) ? 1 : -1);
                npend = pend - sgn;
                ntmr  = 0;
            end
            req = step ? (dir ? 1 : -1) : 0;
            if (npend + req > lim[k] || npend + req < -lim[k]) novf = 1'b1;
            else npend = npend + req;
        end
    endfunction

    always @(posedge clk) begin
        rst_at_edge <= rst;
        cyc <= cyc + 1;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_pend[k] <= 0;
                m_pos[k]  <= 0;
                m_tmr[k]  <= 65535;
                m_ovf[k]  <= 1'b0;
            end else begin
                model_next(k, m_pend[k], m_pos[k], m_tmr[k], np, nq, nt, no);
                m_pend[k] <= np;
                m_pos[k]  <= nq;
                m_tmr[k]  <= nt;
                m_ovf[k]  <= no;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [1:0] ab_d[2];
    int         pend_d[2];
    logic       busy_d[2];
    logic       ovf_d[2];
    logic [1:0] prev_ab[2];
    bit         chk_on = 1'b0;

    assign ab_d[0]   = {a0, b0};
    assign ab_d[1]   = {a1, b1};
    assign pend_d[0] = int'(pend0);
    assign pend_d[1] = int'(pend1);
    assign busy_d[0] = busy0;
    assign busy_d[1] = busy1;
    assign ovf_d[0]  = ovf0;
    assign ovf_d[1]  = ovf1;

    always @(negedge clk) begin
        if (chk_on) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("d%0d_ab", k), ab_d[k], pos_to_ab(m_pos[k]));
                check($sformatf("d%0d_pending", k), pend_d[k], m_pend[k]);
                check($sformatf("d%0d_busy", k), busy_d[k], (m_pend[k] != 0) ? 1 : 0);
                check($sformatf("d%0d_overflow", k), ovf_d[k], m_ovf[k]);
                if (!rst_at_edge)
                    check($sformatf("d%0d_single_toggle", k), ($countones(ab_d[k] ^ prev_ab[k]) <= 1) ? 1 : 0, 1);
            end
        end
        prev_ab[0] <= ab_d[0];
        prev_ab[1] <= ab_d[1];
    end

    // ---------------- edge monitor / loopback reader ----------------
    logic [1:0] exp_q[$];
    int         edge_t[$];
    bit         mon_en = 1'b0;
    logic [1:0] mon_prev0 = 2'b00;
    logic       mon_ovf1 = 1'b0;
    int         edge_cnt0 = 0;
    int         edge_cnt1 = 0;
    int         ovf_pulses1 = 0;
    int         reader_cnt = 0;
    bit         last_dir = 1'b0;

    always @(negedge clk) begin
        int d;
        mon_prev0 <= {a0, b0};
        mon_ovf1  <= ovf1;
        if (rst_at_edge) begin
            edge_cnt0   <= 0;
            edge_cnt1   <= 0;
            ovf_pulses1 <= 0;
            reader_cnt  <= 0;
        end else begin
            if ({a1, b1} != prev_ab[1]) edge_cnt1 <= edge_cnt1 + 1;
            if (ovf1 && !mon_ovf1) ovf_pulses1 <= ovf_pulses1 + 1;
            if ({a0, b0} != mon_prev0) begin
                edge_cnt0 <= edge_cnt0 + 1;
                d = (ab_to_idx({a0, b0}) - ab_to_idx(mon_prev0)) & 3;
                if (d == 1 || d == 3) begin
                    d = (d == 1) ? 1 : -1;
                    if (!pol) d = -d;
                    reader_cnt <= reader_cnt + d;
                    last_dir   <= (d > 0);
                end
                if (mon_en) begin
                    edge_t.push_back(cyc);
                    if (exp_q.size() == 0) check("edge_unexpected", {a0, b0}, 4);
                    else check("edge_ab", {a0, b0}, exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    int req_net = 0;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        step = 1'b0;
        clr  = 1'b0;
        tick(2);
        rst     = 1'b0;
        req_net = 0;
    endtask

    task automatic pulse(input bit d);
        step = 1'b1;
        dir  = d;
        req_net += d ? 1 : -1;
        tick(1);
        step = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((busy0 || busy1) && n < budget) begin
            tick(1);
            n++;
        end
        check("idle_timeout", (busy0 || busy1) ? 1 : 0, 0);
        tick(2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int e0;
        // 1: single step, first edge undelayed
        pol = 1'b1; period = 16'd4; en = 1'b1; dir = 1'b1;
        do_reset();
        chk_on = 1'b1;
        check("t1_reset_ab", {a0, b0}, 2'b00);
        check("t1_reset_pend", pend0, 0);
        check("t1_reset_busy", busy0, 0);
        check("t1_reset_ovf", ovf0, 0);
        mon_en = 1'b1;
        exp_q.push_back(2'b10);
        pulse(1'b1);
        check("t1_pend_after_strobe", pend0, 1);
        check("t1_busy_after_strobe", busy0, 1);
        check("t1_ab_before_edge", {a0, b0}, 2'b00);
        tick(1);
        check("t1_ab_edge", {a0, b0}, 2'b10);
        check("t1_pend_drained", pend0, 0);
        check("t1_busy_drained", busy0, 0);
        tick(4);
        check("t1_queue_empty", exp_q.size(), 0);

        // 2: five back-to-back strobes, period 3
        do_reset();
        edge_t.delete();
        period = 16'd3;
        exp_q.push_back(2'b10); exp_q.push_back(2'b11); exp_q.push_back(2'b01);
        exp_q.push_back(2'b00); exp_q.push_back(2'b10);
        repeat (5) pulse(1'b1);
        wait_idle(100);
        check("t2_queue_empty", exp_q.size(), 0);
        check("t2_edge_count", edge_t.size(), 5);
        for (int i = 1; i < edge_t.size(); i++)
            check($sformatf("t2_spacing_%0d", i), edge_t[i] - edge_t[i-1], 3);
        check("t2_pend_end", pend0, 0);

        // 3: reversal through zero
        do_reset();
        period = 16'd2;
        exp_q.push_back(2'b10); exp_q.push_back(2'b11); exp_q.push_back(2'b10);
        exp_q.push_back(2'b00); exp_q.push_back(2'b01);
        pulse(1'b1); pulse(1'b1); pulse(1'b1);
        pulse(1'b0); pulse(1'b0); pulse(1'b0); pulse(1'b0);
        wait_idle(100);
        check("t3_queue_empty", exp_q.size(), 0);
        check("t3_ab_final", {a0, b0}, 2'b01);
        check("t3_reader_net", reader_cnt, -1);
        check("t3_reader_vs_req", reader_cnt, req_net);
        mon_en = 1'b0;

        // 4: saturation on the 4-bit instance
        do_reset();
        en = 1'b0; period = 16'd1;
        repeat (9) begin
            pulse(1'b1);
            tick(1);
        end
        check("t4_pend_narrow", pend1, 7);
        check("t4_pend_wide", pend0, 9);
        check("t4_ovf_pulses", ovf_pulses1, 2);
        check("t4_no_edges_disabled", edge_cnt0, 0);
        en = 1'b1;
        wait_idle(100);
        check("t4_edges_narrow", edge_cnt1, 7);
        check("t4_edges_wide", edge_cnt0, 9);
        check("t4_ab_narrow", {a1, b1}, 2'b01);
        check("t4_ab_wide", {a0, b0}, 2'b10);

        // 5: clear with a simultaneous step
        do_reset();
        en = 1'b0;
        repeat (5) pulse(1'b1);
        check("t5_pend_before", pend0, 5);
        en = 1'b1; clr = 1'b1; step = 1'b1; dir = 1'b1;
        tick(1);
        clr = 1'b0; step = 1'b0;
        check("t5_pend_cleared", pend0, 0);
        check("t5_pend_cleared_narrow", pend1, 0);
        check("t5_ab_hold", {a0, b0}, 2'b00);
        tick(3);
        check("t5_no_edges", edge_cnt0, 0);

        // 6: loopback at full speed, both polarities (period 0 behaves as 1)
        for (int p = 0; p < 2; p++) begin
            pol = p[0];
            period = p[0] ? 16'd1 : 16'd0;
            do_reset();
            en = 1'b1;
            pulse(1'b1); pulse(1'b1); pulse(1'b0); pulse(1'b1); pulse(1'b0);
            pulse(1'b0); pulse(1'b0); pulse(1'b1); pulse(1'b1); pulse(1'b1);
            wait_idle(100);
            check($sformatf("t6_p%0d_reader_net", p), reader_cnt, 2);
            check($sformatf("t6_p%0d_reader_vs_req", p), reader_cnt, req_net);
            e0 = edge_cnt0;
            repeat (3) pulse(1'b0);
            wait_idle(100);
            check($sformatf("t6_p%0d_neg_edges", p), edge_cnt0 - e0, 3);
            check($sformatf("t6_p%0d_neg_dir", p), last_dir, 0);
            check($sformatf("t6_p%0d_neg_net", p), reader_cnt, -1);
            e0 = edge_cnt0;
            repeat (2) pulse(1'b1);
            wait_idle(100);
            check($sformatf("t6_p%0d_pos_edges", p), edge_cnt0 - e0, 2);
            check($sformatf("t6_p%0d_pos_dir", p), last_dir, 1);
            check($sformatf("t6_p%0d_pos_net", p), reader_cnt, 1);
        end

        // reset mid-sequence returns to 00 and drops pending
        period = 16'd5;
        repeat (6) pulse(1'b1);
        tick(6);
        do_reset();
        check("t7_ab_after_reset", {a0, b0}, 2'b00);
        check("t7_pend_after_reset", pend0, 0);

        tick(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
